// File: rtl/phase_divider.sv
// Free-running phase counter plus an 8-step restoring divider that produces the
// normalized phase floor(count*256/divider) on each accepted sample tick.
module phase_divider #(
  parameter int CNT_W = 18
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CNT_W-1:0] divider,
  input  logic             sample_tick,
  output logic [7:0]       quotient,
  output logic             q_valid,
  output logic             busy,
  output logic             overrun
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    DIV  = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_r, state_s;
  logic [CNT_W-1:0] count_r, count_s;
  logic [CNT_W-1:0] rem_r, rem_s, step_rem_s;
  logic [CNT_W-1:0] div_l_r, div_l_s;
  logic [2:0]       idx_r, idx_s;
  logic [7:0]       qsh_r, qsh_s;
  logic [7:0]       quotient_s;
  logic             q_valid_s, busy_s, overrun_s;
  logic [CNT_W:0]   trial_s, diff_s;
  logic             bit_s;

  // Phase counter next value; a shrunken divider wraps the count at once.
  always_comb begin
    count_s = count_r;
    if (divider == '0) begin
      count_s = '0;
    end else if (count_r >= (divider - ONE)) begin
      count_s = '0;
    end else begin
      count_s = count_r + ONE;
    end
  end

  // One restoring-division step; a zero divisor forces a zero quotient bit.
  always_comb begin
    trial_s    = {rem_r, 1'b0};
    diff_s     = trial_s - {1'b0, div_l_r};
    bit_s      = 1'b0;
    step_rem_s = rem_r;
    if (div_l_r == '0) begin
      bit_s      = 1'b0;
      step_rem_s = rem_r;
    end else if (trial_s >= {1'b0, div_l_r}) begin
      bit_s      = 1'b1;
      step_rem_s = diff_s[CNT_W-1:0];
    end else begin
      bit_s      = 1'b0;
      step_rem_s = trial_s[CNT_W-1:0];
    end
  end

  // FSM next-state and output logic.
  always_comb begin
    state_s    = state_r;
    rem_s      = rem_r;
    div_l_s    = div_l_r;
    idx_s      = idx_r;
    qsh_s      = qsh_r;
    quotient_s = quotient;
    q_valid_s  = 1'b0;
    busy_s     = busy;
    overrun_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (sample_tick) begin
          rem_s   = count_r;
          div_l_s = divider;
          idx_s   = 3'd7;
          qsh_s   = 8'd0;
          busy_s  = 1'b1;
          state_s = DIV;
        end else begin
          busy_s  = 1'b0;
        end
      end
      DIV: begin
        // Ticks during the whole division, including its last edge, are dropped.
        overrun_s = sample_tick;
        rem_s     = step_rem_s;
        qsh_s     = {qsh_r[6:0], bit_s};
        if (idx_r == 3'd0) begin
          quotient_s = {qsh_r[6:0], bit_s};
          q_valid_s  = 1'b1;
          busy_s     = 1'b0;
          state_s    = IDLE;
        end else begin
          idx_s = idx_r - 3'd1;
        end
      end
      default: begin
        state_s = IDLE;
        busy_s  = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= IDLE;
      count_r  <= '0;
      rem_r    <= '0;
      div_l_r  <= '0;
      idx_r    <= 3'd0;
      qsh_r    <= 8'd0;
      quotient <= 8'd0;
      q_valid  <= 1'b0;
      busy     <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      state_r  <= state_s;
      count_r  <= count_s;
      rem_r    <= rem_s;
      div_l_r  <= div_l_s;
      idx_r    <= idx_s;
      qsh_r    <= qsh_s;
      quotient <= quotient_s;
      q_valid  <= q_valid_s;
      busy     <= busy_s;
      overrun  <= overrun_s;
    end
  end

endmodule

// File: tb/tb_phase_divider.sv
// Scoreboard bench for phase_divider: stimulus pushes expected quotients and
// due cycles; a negedge monitor pops and compares on every q_valid.
module tb_phase_divider;
  localparam int CNT_W = 18;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [CNT_W-1:0] divider = '0;
  logic             sample_tick = 1'b0;
  logic [7:0]       quotient;
  logic             q_valid, busy, overrun;

  typedef struct {
    int q;
    int due;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   tb_count = 0;
  int   ov_seen = 0;
  int   nval = 0;

  phase_divider #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .divider(divider), .sample_tick(sample_tick),
    .quotient(quotient), .q_valid(q_valid), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference phase counter, used to know which count a tick captures.
  always @(posedge clk or posedge rst) begin
    if (rst) tb_count <= 0;
    else if (divider == 0) tb_count <= 0;
    else if (tb_count >= int'(divider) - 1) tb_count <= 0;
    else tb_count <= tb_count + 1;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every q_valid consumes one scoreboard entry.
  always @(negedge clk) begin
    if (!rst) begin
      if (q_valid) begin
        nval++;
        if (sb.size() == 0) begin
          chk("spurious_q_valid", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("quotient", int'(quotient), e.q);
          chk("latency_cycle", cyc, e.due);
          chk("busy_at_valid", int'(busy), 0);
        end
      end
      if (overrun) ov_seen++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_count(input int target);
    bit found;
    found = 1'b0;
    for (int k = 0; k < 5000 && !found; k++) begin
      step();
      if (tb_count == target) found = 1'b1;
    end
    if (!found) chk("count_wait_timeout", 0, 1);
  endtask

  task automatic tick_now(input int expq);
    sb.push_back('{expq, cyc + 9});
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    chk("busy_after_tick", int'(busy), 1);
  endtask

  task automatic wait_done();
    for (int k = 0; k < 20 && sb.size() != 0; k++) step();
    chk("scoreboard_drained", sb.size(), 0);
  endtask

  initial begin
    int nv0;
    step();
    step();
    rst = 1'b0;
    step();
    chk("reset_quotient", int'(quotient), 0);
    chk("reset_q_valid", int'(q_valid), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_overrun", int'(overrun), 0);

    // Midpoint
    divider = 18'd1000;
    wait_count(500); tick_now(128); wait_done();

    // Ramp ends
    divider = 18'd256;
    wait_count(255); tick_now(255); wait_done();
    wait_count(0);   tick_now(0);   wait_done();
    divider = 18'd3;
    wait_count(1);   tick_now(85);  wait_done();

    // Note off
    divider = 18'd0;
    step();
    tick_now(0); wait_done();

    // Divider shrink: count 900 wraps to 0, then reaches 5 -> floor(1280/400)=3
    divider = 18'd1000;
    wait_count(900);
    divider = 18'd400;
    repeat (6) step();
    tick_now(3);
    repeat (2) step();
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    chk("overrun_pulse", int'(overrun), 1);
    step();
    chk("overrun_one_cycle", int'(overrun), 0);
    wait_done();

    // Reset mid-division (quotient is 3 beforehand)
    wait_count(100);
    tick_now(64);
    repeat (4) step();
    rst = 1'b1;
    #1;
    chk("abort_quotient", int'(quotient), 0);
    chk("abort_busy", int'(busy), 0);
    void'(sb.pop_back());
    step();
    step();
    rst = 1'b0;
    nv0 = nval;
    repeat (10) step();
    chk("abort_no_q_valid", nval, nv0);
    divider = 18'd1000;
    wait_count(250); tick_now(64); wait_done();

    // Sweep: tick every 9 clocks
    divider = 18'd1000;
    step();
    for (int k = 0; k < 222; k++) begin
      sb.push_back('{(tb_count * 256) / 1000, cyc + 9});
      sample_tick = 1'b1;
      step();
      sample_tick = 1'b0;
      repeat (8) step();
    end
    wait_done();
    chk("overrun_total", ov_seen, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end
endmodule

// File: doc/phase_divider.md
# phase_divider

Upstream oscillator stage of the SynthSurgeons voice path. A free-running phase counter sweeps 0..divider-1 at the system clock. On each sample tick, an 8-iteration sequential restoring divider computes the normalized phase `quotient = floor(count*256/divider)`. The resulting 8-bit ramp and a one-cycle valid strobe drive the waveshaper directly.

## Interface

- `CNT_W`, default 18: width of the phase counter and divider. This covers notes down to roughly 40 Hz at 10 MHz.
- `clk` input 1: system clock; all state changes on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `divider` input CNT_W: oscillator period in clocks (clk_freq / note_freq). 0 means note off.
- `sample_tick` input 1: single-cycle request to compute a new quotient.
- `quotient` output 8: registered normalized phase, to the waveshaper `quotient` input.
- `q_valid` output 1: one-cycle pulse; `quotient` was updated on this edge.
- `busy` output 1: division in progress.
- `overrun` output 1: one-cycle pulse; a `sample_tick` arrived while busy and was dropped.

## Operation

- **Reset** (async, `rst`=1):
  - count=0, quotient=0, q_valid=0, busy=0, overrun=0.
  - State goes to IDLE, and the remainder, latched divisor and bit index are cleared.
- **Phase counter** (every edge, independent of the FSM):
  - If divider==0, count is held at 0.
  - Else if count >= divider-1, count goes to 0. This also catches a divider that shrank below the current count, so the counter never runs past the new period.
  - Otherwise count increments by 1.
- **FSM states: IDLE, DIV.**
- **IDLE + sample_tick=1:**
  - Latch rem=count (the pre-increment value on that edge) and div_l=divider.
  - Set bit index i=7, busy=1, then go to DIV.
- **DIV, once per edge for i=7..0:**
  - t = {rem, 1'b0}, CNT_W+1 bits wide. It cannot overflow, because rem < div_l.
  - If t >= div_l: rem = t - div_l and q[i]=1. Else rem = t and q[i]=0.
  - Quotient bits accumulate in a shadow register. `quotient` stays unchanged until the final iteration.
  - On the i=0 iteration: write the full 8-bit result to `quotient`, pulse q_valid, clear busy, return to IDLE.
- **div_l==0** (note off at tick time): run all 8 iterations anyway so latency stays uniform. The forced result is quotient=0, and q_valid still pulses.
- **Changes to `divider` during DIV** have no effect on the running division, which uses div_l. The counter reacts immediately.
- **sample_tick while busy** (including the edge that completes the division): the tick is ignored and overrun pulses on that edge. There is no queueing.
- **Arithmetic:** unsigned throughout. Since count < divider, the result is always ≤ 255, so 8 bits never saturate. The result is truncated (floor), not rounded.

## Timing

- A tick sampled on edge T captures count(T) and sets busy after T.
- Iterations run on edges T+1..T+8. quotient and q_valid update on edge T+8, and busy falls on edge T+8.
- Latency from tick edge to q_valid edge is 8 clocks.
- The earliest accepted next tick is edge T+9, giving a maximum sample rate of clk/9.
- q_valid is exactly one cycle wide. quotient holds its value until the next completion or reset.
- Asynchronous reset mid-DIV aborts the division immediately:
  - quotient=0 and busy=0.
  - No q_valid is produced for the aborted request.
- Asserting `sample_tick` in the same cycle that reset deasserts has no effect until the first edge with rst=0.

## Test plan

- **Midpoint:** divider=1000. Tick when count=500 → 8 clocks later quotient=128 (0x80), q_valid=1 for one cycle, busy=0.
- **Ramp ends:** divider=256. Tick at count=255 → quotient=255. Tick at count=0 → quotient=0. Tick at count=1 with divider=3 → quotient=85.
- **Note off:** divider=0. Count stays 0. A tick yields quotient=0, with q_valid after exactly 8 clocks.
- **Divider shrink and overrun:**
  - While count=900, change divider from 1000 to 400 → count is 0 on the next edge.
  - Tick, then tick again 3 clocks later → the second tick produces an overrun pulse and no extra q_valid.
- **Reset mid-division:** tick, assert rst 4 clocks later → quotient=0, busy=0, q_valid stays 0. After release, a tick at count=250 with divider=1000 → quotient=64.
- **Sweep:** divider=1000, tick every 9 clocks for 2000 clocks. Every quotient must equal floor(count*256/1000) of the captured count, and no overrun may occur.
